// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM access arbiter.
// RAM_ARB_RSP_REG_EN adds an output register on the read response (RD_LAT 3 instead of 2).
package ram_arb_pkg;

  localparam int ARB_NUM_REQ   = 4;
  localparam int ARB_MEM_DEPTH = 256;
  localparam int ARB_MEM_WIDTH = 32;
  localparam int ARB_AW        = $clog2(ARB_MEM_DEPTH);
  localparam int ARB_IDW       = $clog2(ARB_NUM_REQ);

`ifdef RAM_ARB_RSP_REG_EN
  localparam int RD_LAT = 3;
`else
  localparam int RD_LAT = 2;
`endif

  typedef struct packed {
    logic                     valid;
    logic                     we;
    logic [ARB_AW-1:0]        addr;
    logic [ARB_MEM_WIDTH-1:0] data;
    logic [ARB_IDW-1:0]       id;
  } ram_cmd_t;

  typedef struct packed {
    logic               valid;
    logic [ARB_IDW-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus rotate/priority pick.
// Produces a one-hot grant and the winning index.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  logic [IDW-1:0] ptr_q, ptr_d;
  int             idx;

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
    // Grant is combinational, so it must be suppressed explicitly while in reset.
    if (reset) begin
      gnt       = '0;
      gnt_valid = 1'b0;
      gnt_id    = '0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      if (gnt_id == IDW'(N - 1)) ptr_d = '0;
      else                       ptr_d = gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between NUM_REQ requesters.
// RAM_ARB_RSP_REG_EN registers rsp_data/rsp_valid, adding one cycle of read latency.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int MEM_DEPTH = ARB_MEM_DEPTH,
  parameter int MEM_WIDTH = ARB_MEM_WIDTH,
  localparam int AW  = $clog2(MEM_DEPTH),
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*AW-1:0]          req_addr,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [MEM_WIDTH-1:0]           rsp_data,
  output logic [AW-1:0]                  ram_wr_address,
  output logic [AW-1:0]                  ram_rd_address,
  output logic [MEM_WIDTH-1:0]           ram_write_data,
  output logic                           ram_write_en,
  input  logic [MEM_WIDTH-1:0]           ram_read_data
);

  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  ram_cmd_t       cmd_q, cmd_d;
  rd_tag_t        tag_q [RD_LAT];
  rd_tag_t        tag_d [RD_LAT];

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Address and data hold their last value while idle; only valid drops.
  always_comb begin
    cmd_d       = cmd_q;
    cmd_d.valid = gnt_valid;
    cmd_d.we    = 1'b0;
    if (gnt_valid) begin
      cmd_d.we   = req_we[gnt_id];
      cmd_d.addr = req_addr[int'(gnt_id)*AW +: AW];
      cmd_d.data = req_wdata[int'(gnt_id)*MEM_WIDTH +: MEM_WIDTH];
      cmd_d.id   = gnt_id;
    end
  end

  always_comb begin
    tag_d[0].valid = gnt_valid & ~req_we[gnt_id];
    tag_d[0].id    = gnt_id;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      cmd_q <= cmd_d;
      tag_q <= tag_d;
    end
  end

  assign ram_write_en   = cmd_q.valid & cmd_q.we;
  assign ram_wr_address = cmd_q.addr;
  assign ram_rd_address = cmd_q.addr;
  assign ram_write_data = cmd_q.data;

  always_comb begin
    rsp_valid = '0;
    if (tag_q[RD_LAT-1].valid) rsp_valid[tag_q[RD_LAT-1].id] = 1'b1;
  end

`ifdef RAM_ARB_RSP_REG_EN
  logic [MEM_WIDTH-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    rsp_data_d = tag_q[RD_LAT-2].valid ? ram_read_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_data_q <= '0;
    else       rsp_data_q <= rsp_data_d;
  end

  assign rsp_data = rsp_data_q;
`else
  // Gated so the output reads 0 whenever no response is presented.
  assign rsp_data = tag_q[RD_LAT-1].valid ? ram_read_data : '0;
`endif

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter with a behavioural dual-port RAM.
module tb_ram_access_arbiter;

`ifdef RAM_ARB_RSP_REG_EN
  localparam int RD_LAT = 3;
`else
  localparam int RD_LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = '0;
  logic [3:0]   req_we = '0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [3:0]   gnt;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic [7:0]   ram_wr_address;
  logic [7:0]   ram_rd_address;
  logic [31:0]  ram_write_data;
  logic         ram_write_en;
  logic [31:0]  ram_read_data = '0;

  logic [31:0]  mem [256];
  logic [31:0]  exp_mem [256];
  bit           mem_init = 1'b0;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  ram_access_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .gnt            (gnt),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .ram_wr_address (ram_wr_address),
    .ram_rd_address (ram_rd_address),
    .ram_write_data (ram_write_data),
    .ram_write_en   (ram_write_en),
    .ram_read_data  (ram_read_data)
  );

  // Dual-port RAM, registered read, both clocks tied to clk.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
      mem_init <= 1'b1;
    end else if (ram_write_en) begin
      mem[ram_wr_address] <= ram_write_data;
    end
    ram_read_data <= mem[ram_rd_address];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid != 4'b0) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rsp rsp_valid=%b data=%h cyc=%0d", rsp_valid, rsp_data, cyc);
      end else begin
        e = q.pop_front();
        if (rsp_valid != (4'b1 << e.port) || rsp_data !== e.data || cyc != e.due) begin
          n_err++;
          $display("FAIL rsp got valid=%b data=%h cyc=%0d exp valid=%b data=%h cyc=%0d",
                   rsp_valid, rsp_data, cyc, 4'b1 << e.port, e.data, e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] we, input logic [31:0] a_flat,
                      input logic [31:0] d, input int exp_p, input bit push);
    logic [7:0] a;
    @(negedge clk);
    req = r; req_we = we; req_addr = a_flat; req_wdata = {4{d}};
    #1;
    chk("gnt", 64'(gnt), (exp_p < 0) ? 64'd0 : (64'd1 << exp_p));
    if (exp_p >= 0) begin
      a = a_flat[exp_p*8 +: 8];
      if (we[exp_p]) exp_mem[a] = d;
      else if (push) q.push_back('{port: exp_p, data: exp_mem[a], due: cyc + RD_LAT});
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d exp=0", q.size());
      q.delete();
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk); req = '0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'hA000_0000 + i;

    // Reset state, with all requests up to show gnt is forced low.
    @(negedge clk); req = 4'hF; #1;
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_wen", 64'(ram_write_en), 0);
    chk("rst_addr", 64'({ram_wr_address, ram_rd_address}), 0);
    chk("rst_wdata", 64'(ram_write_data), 0);
    chk("rst_rsp", 64'({rsp_valid, rsp_data}), 0);
    @(negedge clk); req = '0; reset = 1'b0;

    // 1: write then read addr 5 via port 0
    step(4'b0001, 4'b0001, {4{8'd5}}, 32'hDEAD_BEEF, 0, 1'b0);
    step(4'b0001, 4'b0000, {4{8'd5}}, 32'h0, 0, 1'b1);
    chk("wr_en", 64'(ram_write_en), 1);
    chk("wr_addr", 64'(ram_wr_address), 5);
    chk("wr_data", 64'(ram_write_data), 64'h0DEAD_BEEF);
    step(4'b0000, 4'b0000, 32'h0, 32'h0, -1, 1'b0);
    drain();

    // 2: fairness from reset, all four held as reads
    reset_pulse();
    for (int c = 0; c < 8; c++)
      step(4'hF, 4'h0, {8'h23, 8'h22, 8'h21, 8'h20}, 32'h0, c % 4, 1'b1);
    step(4'b0000, 4'b0000, 32'h0, 32'h0, -1, 1'b0);
    drain();

    // 3: back-to-back reads on port 2
    for (int i = 0; i < 16; i++)
      step(4'b0100, 4'b0000, {4{8'(i)}}, 32'h0, 2, 1'b1);
    step(4'b0000, 4'b0000, 32'h0, 32'h0, -1, 1'b0);
    drain();

    // 4: write on port 1 then read same address on port 3 next cycle
    step(4'b0010, 4'b0010, {4{8'd9}}, 32'h0000_1234, 1, 1'b0);
    step(4'b1000, 4'b0000, {4{8'd9}}, 32'h0, 3, 1'b1);
    step(4'b0000, 4'b0000, 32'h0, 32'h0, -1, 1'b0);
    drain();

    // 5: reset one cycle after a read grant; the read must vanish
    step(4'b0001, 4'b0000, {4{8'd5}}, 32'h0, 0, 1'b0);
    @(negedge clk); reset = 1'b1; req = 4'b1001; #1;
    chk("mid_rst_gnt", 64'(gnt), 0);
    chk("mid_rst_wen", 64'(ram_write_en), 0);
    chk("mid_rst_rsp", 64'(rsp_valid), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("in_rst_gnt", 64'(gnt), 0);
      chk("in_rst_rsp", 64'(rsp_valid), 0);
    end
    @(negedge clk); reset = 1'b0; req = '0;
    step(4'b1001, 4'b0000, {4{8'd5}}, 32'h0, 0, 1'b1);
    step(4'b0000, 4'b0000, 32'h0, 32'h0, -1, 1'b0);
    drain();

    // 6: idle, pointer must stay at 1
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 4'b0000, 32'h0, 32'h0, -1, 1'b0);
      chk("idle_wen", 64'(ram_write_en), 0);
      chk("idle_rsp", 64'(rsp_valid), 0);
    end
    step(4'hF, 4'h0, {8'h33, 8'h32, 8'h31, 8'h30}, 32'h0, 1, 1'b1);
    step(4'b0000, 4'b0000, 32'h0, 32'h0, -1, 1'b0);
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
